tcam_match_encoder: RTL
=======================

# tcam_match_encoder

Pipelined priority encoder directly downstream of the 120-rule TCAM row. Consumes the 120-bit per-rule match vector produced for each key lookup and returns the index of the highest-priority matching rule, a hit flag and running lookup/miss statistics. Uses a valid/ready handshake on both sides so the lookup source can be stalled by the result consumer.

## Interface
- `NUM_RULES`, 120: width of the match vector; rule 0 is highest priority.
- `GROUP_W`, 8: rules per stage-1 group, one group per 8-rule RAM slice.
- `CNT_W`, 16: width of the statistics counters.

- `write_clk`  in  1: single clock for the block.
- `rst`  in  1: synchronous, active-high reset.
- `match_valid`  in  1: `match` holds a lookup result.
- `match_ready`  out  1: block accepts `match` this cycle.
- `match`  in  120: per-rule match bits, bit i set means rule i matched.
- `result_valid`  out  1: result fields valid.
- `result_ready`  in  1: consumer accepts the result.
- `hit`  out  1: at least one rule matched.
- `rule_idx`  out  7: lowest matching rule index; 0 on miss.
- `multi_hit`  out  1: more than one rule matched. Present only with `TCAM_MULTI_HIT_EN`.
- `stat_clr`  in  1: clears both counters.
- `lookup_cnt`  out  CNT_W: accepted results, saturating.
- `miss_cnt`  out  CNT_W: accepted results with `hit`=0, saturating.

## Operation
- Stage 1 splits `match` into 15 groups of 8 bits: group g covers bits [8g+7:8g]. For each group it registers `grp_hit[g]` (OR of the group) and `grp_idx[g]` (3-bit lowest set bit, 0 if none). With `TCAM_MULTI_HIT_EN` it also registers `grp_multi[g]`, meaning more than one bit in group g is set.
- Stage 2 selects the lowest g with `grp_hit[g]`. It registers `hit` = OR(`grp_hit`) and `rule_idx` = g*8 + `grp_idx[g]`, or 0 if there is no hit.
- `multi_hit` = any `grp_multi` OR (at least two `grp_hit` bits set).
- Rule index range is 0..119; values 120..127 are never produced.
- Counters update on the output handshake (`result_valid` && `result_ready`):
  - `lookup_cnt` increments by 1.
  - `miss_cnt` increments by 1 when `hit`=0.
  - Both counters saturate at all-ones and do not wrap.
- `stat_clr` forces both counters to 0 and takes priority over a same-cycle increment.
- Reset: `result_valid`, `hit`, `rule_idx`, `multi_hit`, `lookup_cnt`, `miss_cnt` and both stage-valid flags are 0. `match_ready` is 1 in the first cycle after reset.
- Reset mid-operation flushes in-flight lookups. They are never presented and never counted.

## Timing
- Latency: `match` is accepted in cycle N; the result is visible with `result_valid`=1 in cycle N+2 when there is no backpressure.
- Throughput: one lookup per cycle.
- Stage k advances when it is empty or stage k+1 advances in the same cycle (full pipelining, no bubble).
- `match_ready` = !s1_valid || s2_advance. It is combinational from `result_ready`; no combinational path from `match_valid` to any output.
- While `result_valid`=1 and `result_ready`=0:
  - `hit`, `rule_idx` and `multi_hit` hold stable.
  - The pipeline holds up to 2 lookups, then `match_ready` drops to 0.
- `match` is sampled only when `match_valid` && `match_ready`; it is don't-care otherwise.

## Configuration
- `TCAM_MULTI_HIT_EN` defined:
  - `grp_multi` registers and the `multi_hit` port exist.
  - `multi_hit` resets to 0 and is held under backpressure like the other result fields.
- Not defined:
  - `multi_hit` port and all associated logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package `tcam_pkg`: `NUM_RULES`=120, `GROUP_W`=8, `NUM_GROUPS`=15, `IDX_W`=7, and typedef `rule_idx_t` (7-bit). The TCAM row and downstream action-lookup stages reuse them.
- Sub-module `pri_enc8`: combinational 8-to-3 lowest-set-bit encoder with `any` output, plus `multi` output under the macro. Instantiated 15× in stage 1 and once (extended to 15 inputs) or inline in stage 2.

## Test plan
- Reset then single lookups, `result_ready`=1:
  - `match`=bit 37 only -> 2 cycles later `hit`=1, `rule_idx`=37.
  - `match`=0 -> `hit`=0, `rule_idx`=0, `miss_cnt`=1.
- Priority: `match` bits {119, 64, 9} -> `rule_idx`=9, `multi_hit`=1. Bits {8} only -> `rule_idx`=8, `multi_hit`=0. Bit 119 only -> `rule_idx`=119.
- Back-to-back lookups of 100 random vectors with `result_ready`=1 every cycle -> results in order at 1/cycle, each equal to the reference lowest set bit, `lookup_cnt`=100.
- Backpressure: `result_ready`=0 for 5 cycles while feeding 3 lookups -> `match_ready`=0 after 2 accepted, outputs held stable. On release, results 1, 2, 3 appear in order with no loss or duplication.
- Counters: preload by 65 535 accepted misses then one more -> `lookup_cnt`=`miss_cnt`=0xFFFF (saturated). `stat_clr` asserted on the same cycle as a handshake -> both 0 next cycle.
- Reset mid-flight: `rst` pulsed with 2 lookups in the pipeline -> next cycle `result_valid`=0, counters 0, flushed lookups never appear.

Source files
------------

// File: rtl/tcam_pkg.sv
// Shared TCAM constants and types, reused by the TCAM row, the match
// encoder and the downstream action-lookup stages.
`timescale 1ns/1ps
package tcam_pkg;
   localparam int NUM_RULES  = 120;
   localparam int GROUP_W    = 8;
   localparam int NUM_GROUPS = NUM_RULES / GROUP_W;
   localparam int IDX_W      = 7;
   localparam int GRP_IDX_W  = 3;
   localparam int CNT_W      = 16;

   typedef logic [IDX_W-1:0] rule_idx_t;
endpackage

// File: rtl/tcam_match_encoder_pri_enc8.sv
// pri_enc8: combinational 8-to-3 lowest-set-bit encoder.
// Optional feature macro: TCAM_MULTI_HIT_EN adds the `multi` output
// (more than one input bit set).
`timescale 1ns/1ps
module pri_enc8 (
   input  logic [7:0] bits,
   output logic       any,
`ifdef TCAM_MULTI_HIT_EN
   output logic       multi,
`endif
   output logic [2:0] idx
);

   // Scan from the top so the lowest set bit wins the last assignment.
   always_comb begin
      any = |bits;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (bits[i]) idx = 3'(i);
      end
   end

`ifdef TCAM_MULTI_HIT_EN
   // Clearing the lowest set bit leaves something only if two or more were set.
   always_comb begin
      multi = (bits & (bits - 8'd1)) != 8'd0;
   end
`endif

endmodule

// File: rtl/tcam_match_encoder.sv
// tcam_match_encoder: two-stage pipelined priority encoder for the
// 120-rule TCAM match vector, with valid/ready on both sides and
// saturating lookup/miss statistics.
// Optional feature macro: TCAM_MULTI_HIT_EN adds the multi_hit result.
`timescale 1ns/1ps
module tcam_match_encoder
   import tcam_pkg::*;
(
   input  logic                 write_clk,
   input  logic                 rst,
   input  logic                 match_valid,
   output logic                 match_ready,
   input  logic [NUM_RULES-1:0] match,
   output logic                 result_valid,
   input  logic                 result_ready,
   output logic                 hit,
   output logic [IDX_W-1:0]     rule_idx,
`ifdef TCAM_MULTI_HIT_EN
   output logic                 multi_hit,
`endif
   input  logic                 stat_clr,
   output logic [CNT_W-1:0]     lookup_cnt,
   output logic [CNT_W-1:0]     miss_cnt
);

   logic                  s1_valid;
   logic                  s2_advance;
   logic                  out_fire;
   logic [NUM_GROUPS-1:0] enc_any;
   logic [GRP_IDX_W-1:0]  enc_idx [NUM_GROUPS];
   logic [NUM_GROUPS-1:0] grp_hit;
   logic [GRP_IDX_W-1:0]  grp_idx [NUM_GROUPS];
   rule_idx_t             sel_idx;
`ifdef TCAM_MULTI_HIT_EN
   logic [NUM_GROUPS-1:0] enc_multi;
   logic [NUM_GROUPS-1:0] grp_multi;
   logic                  sel_multi;
`endif

   // The output register is the last stage; stage 1 moves whenever it can.
   assign s2_advance  = !result_valid || result_ready;
   assign match_ready = !s1_valid || s2_advance;
   assign out_fire    = result_valid && result_ready;

   for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
      pri_enc8 u_enc (
         .bits  (match[g*GROUP_W +: GROUP_W]),
         .any   (enc_any[g]),
`ifdef TCAM_MULTI_HIT_EN
         .multi (enc_multi[g]),
`endif
         .idx   (enc_idx[g])
      );
   end

   // Stage 1: register per-group hit/index summaries of an accepted match.
   always_ff @(posedge write_clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         grp_hit  <= '0;
         grp_idx  <= '{default: '0};
`ifdef TCAM_MULTI_HIT_EN
         grp_multi <= '0;
`endif
      end else if (match_ready) begin
         s1_valid <= match_valid;
         if (match_valid) begin
            grp_hit <= enc_any;
            grp_idx <= enc_idx;
`ifdef TCAM_MULTI_HIT_EN
            grp_multi <= enc_multi;
`endif
         end
      end
   end

   // Lowest hitting group wins; its base plus the in-group index is the rule.
   always_comb begin
      sel_idx = '0;
      for (int g = NUM_GROUPS - 1; g >= 0; g--) begin
         if (grp_hit[g]) sel_idx = rule_idx_t'(g * GROUP_W) + rule_idx_t'(grp_idx[g]);
      end
   end

`ifdef TCAM_MULTI_HIT_EN
   // Multiple hits either inside one group or spread across two groups.
   always_comb begin
      sel_multi = (|grp_multi) || ((grp_hit & (grp_hit - NUM_GROUPS'(1))) != '0);
   end
`endif

   // Stage 2: result register, held while the consumer stalls.
   always_ff @(posedge write_clk) begin
      if (rst) begin
         result_valid <= 1'b0;
         hit          <= 1'b0;
         rule_idx     <= '0;
`ifdef TCAM_MULTI_HIT_EN
         multi_hit    <= 1'b0;
`endif
      end else if (s2_advance) begin
         result_valid <= s1_valid;
         if (s1_valid) begin
            hit      <= |grp_hit;
            rule_idx <= sel_idx;
`ifdef TCAM_MULTI_HIT_EN
            multi_hit <= sel_multi;
`endif
         end
      end
   end

   // Statistics count delivered results only; clear beats increment.
   always_ff @(posedge write_clk) begin
      if (rst || stat_clr) begin
         lookup_cnt <= '0;
         miss_cnt   <= '0;
      end else if (out_fire) begin
         if (lookup_cnt != '1) lookup_cnt <= lookup_cnt + CNT_W'(1);
         if (!hit && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_W'(1);
      end
   end

endmodule
